// File: rtl/audio_frame_streamer.sv
// audio_frame_streamer
//   Stereo frame FIFO plus fixed-rate pacer feeding two 8-bit excess-128 DACs.
//   A producer pushes {left,right} frames over valid/ready. Once every CLK_DIV
//   cycles the block loads the outputs: in FILL it waits for PREFILL frames
//   and emits silence (0x80) until then; in PLAY it pops one frame per period.
//   If PLAY finds the FIFO empty, it emits silence, sets the sticky underrun
//   flag and drops back to FILL.
//
// Ports
//   clk, reset              system clock, synchronous active-high reset
//   in_left/in_right        producer frame, excess-128
//   in_valid/in_ready       push handshake (in_ready = not full, registered)
//   out_left/out_right      registered DAC samples
//   sample_strobe           one-cycle pulse aligned with each output load
//   playing                 high while in PLAY
//   underrun/underrun_clr   sticky empty-on-pop flag and its clear
//   level                   frames currently buffered (0..2^DEPTH_LOG2)
module audio_frame_streamer #(
  parameter int CLK_DIV    = 7000,
  parameter int DEPTH_LOG2 = 4,
  parameter int PREFILL    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_left,
  input  logic [7:0]            in_right,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            out_left,
  output logic [7:0]            out_right,
  output logic                  sample_strobe,
  output logic                  playing,
  output logic                  underrun,
  input  logic                  underrun_clr,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]      DIV_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]      DIV_ONE     = DIV_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE     = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE     = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   LVL_FULL    = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_PREFILL = (DEPTH_LOG2 + 1)'(PREFILL);
  localparam logic [7:0]            SILENCE     = 8'h80;

  typedef enum logic {
    FILL = 1'b0,
    PLAY = 1'b1
  } state_e;

  state_e                  state_q;
  logic [DIV_W-1:0]        div_q;
  logic [DEPTH_LOG2-1:0]   wptr_q;
  logic [DEPTH_LOG2-1:0]   rptr_q;
  logic [DEPTH_LOG2:0]     level_q;
  logic [DEPTH_LOG2:0]     level_d;
  logic [15:0]             mem_q [DEPTH];
  logic [7:0]              out_left_q;
  logic [7:0]              out_right_q;
  logic                    strobe_q;
  logic                    underrun_q;

  logic                    tick;
  logic                    push;
  logic                    pop;
  logic                    underrun_set;
  logic [15:0]             head;

  assign tick     = (div_q == DIV_LAST);
  // Decoded from registered level only, so no combinational path from in_valid.
  assign in_ready = (level_q != LVL_FULL);
  assign push     = in_valid & in_ready;
  assign head     = mem_q[rptr_q];

  // PREFILL >= 1, so the FILL condition also guarantees the FIFO is non-empty.
  always_comb begin
    pop = 1'b0;
    if (tick) begin
      if (state_q == FILL) pop = (level_q >= LVL_PREFILL);
      else                 pop = (level_q != '0);
    end
  end

  assign underrun_set = tick && (state_q == PLAY) && (level_q == '0);

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wptr_q] <= {in_left, in_right};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      div_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      out_left_q  <= SILENCE;
      out_right_q <= SILENCE;
      strobe_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      div_q    <= tick ? '0 : div_q + DIV_ONE;
      level_q  <= level_d;
      strobe_q <= tick;
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;

      if (tick) begin
        if (pop) begin
          out_left_q  <= head[15:8];
          out_right_q <= head[7:0];
          state_q     <= PLAY;
        end else begin
          out_left_q  <= SILENCE;
          out_right_q <= SILENCE;
          state_q     <= FILL;
        end
      end

      // Set has priority over clear.
      if (underrun_set)      underrun_q <= 1'b1;
      else if (underrun_clr) underrun_q <= 1'b0;
    end
  end

  assign out_left      = out_left_q;
  assign out_right     = out_right_q;
  assign sample_strobe = strobe_q;
  assign playing       = (state_q == PLAY);
  assign underrun      = underrun_q;
  assign level         = level_q;

endmodule

// File: tb/tb_audio_frame_streamer.sv
module tb_audio_frame_streamer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_left;
  logic [7:0] in_right;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_left;
  logic [7:0] out_right;
  logic       sample_strobe;
  logic       playing;
  logic       underrun;
  logic       underrun_clr;
  logic [2:0] level;

  int unsigned n_vec;
  int unsigned n_err;
  logic [15:0] exp_q[$];

  audio_frame_streamer #(
    .CLK_DIV    (4),
    .DEPTH_LOG2 (2),
    .PREFILL    (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_left       (in_left),
    .in_right      (in_right),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_left      (out_left),
    .out_right     (out_right),
    .sample_strobe (sample_strobe),
    .playing       (playing),
    .underrun      (underrun),
    .underrun_clr  (underrun_clr),
    .level         (level)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [7:0] l, input logic [7:0] r);
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Checks the cycle right after a tick edge against the model head (or silence).
  task automatic check_load(input string tag, input logic silent, input logic exp_play,
                            input logic [2:0] exp_lvl);
    logic [15:0] e;
    if (silent) e = 16'h8080;
    else if (exp_q.size() == 0) e = 16'hxxxx;
    else e = exp_q.pop_front();
    check_eq({tag, "_strobe"}, 32'(sample_strobe), 32'd1);
    check_eq({tag, "_out"}, 32'({out_left, out_right}), 32'(e));
    check_eq({tag, "_play"}, 32'(playing), 32'(exp_play));
    check_eq({tag, "_lvl"}, 32'(level), 32'(exp_lvl));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    underrun_clr = 1'b0;
    drive(8'h55, 8'hAA);

    // Reset with a push attempted
    step(2);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_out", 32'({out_left, out_right}), 32'h8080);
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    check_eq("rst_strobe", 32'(sample_strobe), 32'd0);
    check_eq("rst_play", 32'(playing), 32'd0);
    check_eq("rst_underrun", 32'(underrun), 32'd0);
    reset = 1'b0;
    idle();
    for (int unsigned i = 0; i < 3; i++) begin
      step(1);
      check_eq("rst_nostrobe", 32'(sample_strobe), 32'd0);
    end
    step(1);
    check_load("rst_tick", 1'b1, 1'b0, 3'd0);
    step(1);
    check_eq("strobe_width", 32'(sample_strobe), 32'd0);

    // Prefill then play
    drive(8'h10, 8'h90); exp_q.push_back(16'h1090);
    step(1);
    check_eq("pf_lvl1", 32'(level), 32'd1);
    drive(8'h11, 8'h91); exp_q.push_back(16'h1191);
    step(1);
    check_eq("pf_lvl2", 32'(level), 32'd2);
    check_eq("pf_noplay", 32'(playing), 32'd0);
    idle();
    step(1);
    check_load("pf_first", 1'b0, 1'b1, 3'd1);
    step(4);
    check_load("pf_second", 1'b0, 1'b1, 3'd0);

    // Underrun from an empty PLAY, then stickiness and clear
    step(4);
    check_load("ur_tick", 1'b1, 1'b0, 3'd0);
    check_eq("ur_set", 32'(underrun), 32'd1);
    step(4);
    check_load("ur_fill", 1'b1, 1'b0, 3'd0);
    check_eq("ur_sticky", 32'(underrun), 32'd1);
    underrun_clr = 1'b1;
    step(1);
    underrun_clr = 1'b0;
    check_eq("ur_clr", 32'(underrun), 32'd0);

    // Full FIFO: 5th frame held off until a pop frees a slot
    step(1);
    drive(8'h31, 8'hB1); exp_q.push_back(16'h31B1);
    step(1);
    check_eq("full_lvl1", 32'(level), 32'd1);
    drive(8'h32, 8'hB2); exp_q.push_back(16'h32B2);
    step(1);
    check_load("full_silence", 1'b1, 1'b0, 3'd2);
    drive(8'h33, 8'hB3); exp_q.push_back(16'h33B3);
    step(1);
    check_eq("full_lvl3", 32'(level), 32'd3);
    drive(8'h34, 8'hB4); exp_q.push_back(16'h34B4);
    step(1);
    check_eq("full_lvl4", 32'(level), 32'd4);
    check_eq("full_notready", 32'(in_ready), 32'd0);
    drive(8'h35, 8'hB5);
    step(1);
    check_eq("full_reject_lvl", 32'(level), 32'd4);
    check_eq("full_reject_rdy", 32'(in_ready), 32'd0);
    step(1);
    check_load("full_pop", 1'b0, 1'b1, 3'd3);
    check_eq("full_ready_again", 32'(in_ready), 32'd1);
    exp_q.push_back(16'h35B5);
    step(1);
    idle();
    check_eq("full_accept5", 32'(level), 32'd4);
    check_eq("full_notready2", 32'(in_ready), 32'd0);

    // Drain to level 2, then push on every tick across pointer wrap
    step(3);
    check_load("wrap_pre1", 1'b0, 1'b1, 3'd3);
    step(4);
    check_load("wrap_pre2", 1'b0, 1'b1, 3'd2);
    for (int unsigned k = 0; k < 8; k++) begin
      step(3);
      drive(8'h20 + 8'(k), 8'hA0 + 8'(k));
      step(1);
      idle();
      check_load("wrap_pp", 1'b0, 1'b1, 3'd2);
      exp_q.push_back({8'h20 + 8'(k), 8'hA0 + 8'(k)});
    end

    // Drain, underrun with simultaneous clear (set wins), then resume
    step(4);
    check_load("drain1", 1'b0, 1'b1, 3'd1);
    step(4);
    check_load("drain2", 1'b0, 1'b1, 3'd0);
    check_eq("drain_noflag", 32'(underrun), 32'd0);
    step(3);
    underrun_clr = 1'b1;
    step(1);
    underrun_clr = 1'b0;
    check_load("ur2_tick", 1'b1, 1'b0, 3'd0);
    check_eq("ur2_set_wins", 32'(underrun), 32'd1);
    drive(8'h41, 8'hC1); exp_q.push_back(16'h41C1);
    step(1);
    idle();
    step(3);
    check_load("resume_wait", 1'b1, 1'b0, 3'd1);
    drive(8'h42, 8'hC2); exp_q.push_back(16'h42C2);
    step(1);
    idle();
    check_eq("resume_lvl2", 32'(level), 32'd2);
    step(3);
    check_load("resume_play", 1'b0, 1'b1, 3'd1);

    // Mid-run reset with a push in the reset cycle
    drive(8'h43, 8'hC3);
    step(1);
    drive(8'h44, 8'hC4);
    step(1);
    check_eq("mr_lvl3", 32'(level), 32'd3);
    check_eq("mr_play", 32'(playing), 32'd1);
    reset = 1'b1;
    drive(8'h45, 8'hC5);
    step(1);
    reset = 1'b0;
    idle();
    exp_q.delete();
    check_eq("mr_level", 32'(level), 32'd0);
    check_eq("mr_out", 32'({out_left, out_right}), 32'h8080);
    check_eq("mr_play0", 32'(playing), 32'd0);
    check_eq("mr_underrun", 32'(underrun), 32'd0);
    check_eq("mr_ready", 32'(in_ready), 32'd1);
    for (int unsigned i = 0; i < 3; i++) begin
      step(1);
      check_eq("mr_nostrobe", 32'(sample_strobe), 32'd0);
    end
    step(1);
    check_load("mr_tick", 1'b1, 1'b0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/audio_frame_streamer.md
# audio_frame_streamer

Stereo sample buffer and rate pacer that sits directly upstream of the 8-bit delta-sigma `dac` instances. A producer (SD/flash loader, CPU, test pattern engine) pushes stereo frames through a valid/ready handshake into a small FIFO. The block pops one frame per sample period and presents it as excess-128 `DACin` words for the left and right DACs. It prefills before playing, outputs midscale silence on underrun, and flags underruns to the producer.

## Interface
- `CLK_DIV`, 7000, clock cycles per sample period (14 MHz / 7000 = 2 kHz); legal range ≥ 2.
- `DEPTH_LOG2`, 4, FIFO depth = 2^DEPTH_LOG2 frames.
- `PREFILL`, 8, frames required in the FIFO before playback starts; legal range 1..2^DEPTH_LOG2.
- `clk`  in  1  system clock (14 MHz); all logic on the rising edge.
- `reset`  in  1  synchronous, active-high; flushes FIFO and returns block to prefill.
- `in_left`  in  8  left sample, excess-128 (0x80 = silence).
- `in_right`  in  8  right sample, excess-128.
- `in_valid`  in  1  producer has a frame on `in_left`/`in_right`.
- `in_ready`  out  1  FIFO can accept a frame; equals not-full.
- `out_left`  out  8  registered sample for the left DAC.
- `out_right`  out  8  registered sample for the right DAC.
- `sample_strobe`  out  1  one-cycle pulse when `out_*` take a new value.
- `playing`  out  1  high in PLAY state.
- `underrun`  out  1  sticky; set when a pop is required and the FIFO is empty.
- `underrun_clr`  in  1  clears `underrun`.
- `level`  out  DEPTH_LOG2+1  frames currently stored (0..2^DEPTH_LOG2).

## Operation
- Push: a frame is written when `in_valid & in_ready` at a clock edge. `in_ready` = (`level` != 2^DEPTH_LOG2) and is decoded from registered `level` only, with no combinational path from `in_valid`.
- Pacer: counter `div` runs 0..CLK_DIV-1 and wraps. `tick` is asserted while `div == CLK_DIV-1`. The counter runs in all states.
- State FILL (reset state), evaluated on each tick:
  - If `level >= PREFILL`: pop one frame, load `out_*` with it, go to PLAY.
  - Otherwise: load `out_*` with 0x80/0x80 and stay in FILL.
- State PLAY, evaluated on each tick:
  - If `level != 0`: pop the head frame into `out_*`.
  - If `level == 0`: load 0x80/0x80, set `underrun`, go to FILL.
- `sample_strobe` is asserted on every tick-driven load in both states, including silence loads.
- Simultaneous push and pop in one cycle: both take effect and `level` is unchanged. A push into a full FIFO in the same cycle as a pop is not accepted, because `in_ready` was already 0.
- FIFO pointers are DEPTH_LOG2 bits and wrap modulo depth. `level` is a separate counter: +1 on push only, -1 on pop only.
- FIFO data is frame-atomic (16 bits); left and right are never split.
- `underrun`: if set and clear occur in the same cycle, set wins. `underrun_clr` does not affect the state machine.
- `playing` = (state == PLAY).

## Timing
- Reset values: `out_left` = `out_right` = 0x80, `sample_strobe` = 0, `underrun` = 0, `level` = 0, `in_ready` = 1, `playing` = 0, `div` = 0, state FILL, both pointers 0.
- Reset asserted mid-operation discards all buffered frames at the next edge. A push in the reset cycle is ignored.
- First tick after reset is at cycle CLK_DIV-1 (cycles counted from the first edge with `reset` low).
- `out_*`, `sample_strobe`, `playing` and `level` all update on the edge that ends the tick cycle. `sample_strobe` is high for exactly one cycle, aligned with the new `out_*` value.
- Push-to-`level` latency: 1 cycle. Pop-to-output latency: 0 cycles beyond the tick edge.
- Output sample rate is exactly clk / CLK_DIV. There is no jitter, and it is independent of producer activity.

## Test plan
Use CLK_DIV=4, DEPTH_LOG2=2, PREFILL=2.
- **Reset state:** assert `reset` with `in_valid`=1 → `level`=0, `out_*`=0x80, `in_ready`=1, no strobe. After release, strobes pulse every 4 cycles with `out_*`=0x80 and `playing`=0.
- **Prefill then play:** push (0x10,0x90) and (0x11,0x91) → at the next tick `out_*`=(0x10,0x90) and `playing`=1. Next tick `out_*`=(0x11,0x91).
- **Full:** push 5 frames back-to-back with no tick due → `in_ready`=0 after the 4th, `level`=4, 5th frame not accepted. After the next pop, `in_ready`=1 and the 5th frame is accepted when re-presented.
- **Simultaneous push/pop:** in PLAY with `level`=2, push on the tick cycle → `level` stays 2 and output order is preserved across pointer wrap for ≥8 frames.
- **Underrun:** in PLAY, drain the FIFO, no pushes → next tick `out_*`=0x80, `underrun`=1, `playing`=0. Asserting `underrun_clr` and an underrun set in the same cycle leaves `underrun`=1. Playback resumes only after `level` reaches 2.
- **Mid-run reset:** `level`=3 in PLAY, pulse `reset` → `level`=0, `out_*`=0x80, `playing`=0, `underrun`=0. The divider restarts so the first tick is 3 cycles after reset release.
